// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding (MEM / WB / WB-hold) and load-use stall control.
// A delayed copy of the WB write covers the register-file write-then-read gap.
module forward_hazard_unit #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int FWD_HOLD = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] ex_rt,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_memread,
    input  logic          ex_alusrc,
    input  logic [DW-1:0] ex_rs_data,
    input  logic [DW-1:0] ex_rt_data,
    input  logic [DW-1:0] ex_imm,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_regwrite,
    input  logic [DW-1:0] mem_alu_out,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_regwrite,
    input  logic [DW-1:0] wb_data,
    input  logic          pipe_flush,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [DW-1:0] store_data,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          stall,
    output logic          bubble,
    output logic [15:0]   stall_cnt
);

    // state | meaning
    // IDLE  | no stall pending; stall/bubble follow the live hazard
    // WAIT  | first stall cycle issued; rem further stall cycles remain
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [1:0] SRC_RF   = 2'b00;
    localparam logic [1:0] SRC_MEM  = 2'b10;
    localparam logic [1:0] SRC_WB   = 2'b01;
    localparam logic [1:0] SRC_HOLD = 2'b11;
    localparam logic       HOLD_EN  = (FWD_HOLD != 0);
    localparam logic [2:0] LAT_M1   = 3'(LOAD_LAT - 1);

    state_t        state_q;
    logic [2:0]    rem_q;
    logic          hold_valid_q;
    logic [AW-1:0] hold_rd_q;
    logic [DW-1:0] hold_data_q;
    logic [15:0]   stall_cnt_q;

    logic          hold_hit_a, hold_hit_b;
    logic [DW-1:0] fwd_b_val;
    logic          hz;
    logic          stall_d;

    assign hold_hit_a = HOLD_EN && hold_valid_q && (hold_rd_q == ex_rs);
    assign hold_hit_b = HOLD_EN && hold_valid_q && (hold_rd_q == ex_rt);

    always_comb begin
        fwd_a = SRC_RF;
        op_a  = ex_rs_data;
        if (ex_rs != '0) begin
            if (mem_regwrite && (mem_rd == ex_rs)) begin
                fwd_a = SRC_MEM;
                op_a  = mem_alu_out;
            end else if (wb_regwrite && (wb_rd == ex_rs)) begin
                fwd_a = SRC_WB;
                op_a  = wb_data;
            end else if (hold_hit_a) begin
                fwd_a = SRC_HOLD;
                op_a  = hold_data_q;
            end
        end
    end

    always_comb begin
        fwd_b     = SRC_RF;
        fwd_b_val = ex_rt_data;
        if (ex_rt != '0) begin
            if (mem_regwrite && (mem_rd == ex_rt)) begin
                fwd_b     = SRC_MEM;
                fwd_b_val = mem_alu_out;
            end else if (wb_regwrite && (wb_rd == ex_rt)) begin
                fwd_b     = SRC_WB;
                fwd_b_val = wb_data;
            end else if (hold_hit_b) begin
                fwd_b     = SRC_HOLD;
                fwd_b_val = hold_data_q;
            end
        end
    end

    assign op_b       = ex_alusrc ? ex_imm : fwd_b_val;
    assign store_data = fwd_b_val;

    assign hz = ex_memread && (ex_rd != '0) &&
                ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

    always_comb begin
        stall_d = 1'b0;
        if (!pipe_flush) begin
            stall_d = (state_q == WAIT) ? 1'b1 : hz;
        end
    end

    // Gate with rst_n so a hazard seen during reset never leaks out as a stall.
    assign stall     = stall_d & rst_n;
    assign bubble    = stall;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= wb_regwrite && (wb_rd != '0);
            hold_rd_q    <= wb_rd;
            hold_data_q  <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= 3'd0;
        end else if (pipe_flush) begin
            state_q <= IDLE;
            rem_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hz && (LOAD_LAT > 1)) begin
                        state_q <= WAIT;
                        rem_q   <= LAT_M1;
                    end
                end
                WAIT: begin
                    rem_q <= rem_q - 3'd1;
                    if (rem_q == 3'd1) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rem_q   <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else if (stall_d && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: two instances (LOAD_LAT 3 with hold, LOAD_LAT 1 without)
// checked every cycle against a behavioural model, plus literal scenario checks.
module tb_forward_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        id_use_rs, id_use_rt, ex_memread, ex_alusrc, mem_regwrite, wb_regwrite, pipe_flush;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, mem_alu_out, wb_data;

    logic [31:0] op_a_h, op_b_h, sd_h, op_a_l, op_b_l, sd_l;
    logic [1:0]  fa_h, fb_h, fa_l, fb_l;
    logic        st_h, bu_h, st_l, bu_l;
    logic [15:0] cnt_h, cnt_l;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    forward_hazard_unit #(.DW(32), .AW(5), .LOAD_LAT(3), .FWD_HOLD(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_alusrc(ex_alusrc), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_alu_out(mem_alu_out), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
        .pipe_flush(pipe_flush), .op_a(op_a_h), .op_b(op_b_h), .store_data(sd_h),
        .fwd_a(fa_h), .fwd_b(fb_h), .stall(st_h), .bubble(bu_h), .stall_cnt(cnt_h));

    forward_hazard_unit #(.DW(32), .AW(5), .LOAD_LAT(1), .FWD_HOLD(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_alusrc(ex_alusrc), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_alu_out(mem_alu_out), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
        .pipe_flush(pipe_flush), .op_a(op_a_l), .op_b(op_b_l), .store_data(sd_l),
        .fwd_a(fa_l), .fwd_b(fb_l), .stall(st_l), .bubble(bu_l), .stall_cnt(cnt_l));

    // Model: last WB write remembered, and per instance the stall cycles still owed.
    int          m_lat[2]     = '{3, 1};
    bit          m_hold_en[2] = '{1'b1, 1'b0};
    int          m_owed[2];
    int          m_cnt[2];
    bit          m_hv;
    logic [4:0]  m_hrd;
    logic [31:0] m_hdata;

    function automatic bit m_hz();
        if (!ex_memread || ex_rd == 5'd0) return 1'b0;
        return (id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd);
    endfunction

    function automatic bit m_stall(int k);
        if (!rst_n || pipe_flush) return 1'b0;
        if (m_owed[k] > 0) return 1'b1;
        return m_hz();
    endfunction

    function automatic logic [33:0] m_fwd(input logic [4:0] s, input logic [31:0] rf, input bit hold_en);
        if (s == 5'd0)                    return {2'b00, rf};
        if (mem_regwrite && mem_rd == s)  return {2'b10, mem_alu_out};
        if (wb_regwrite && wb_rd == s)    return {2'b01, wb_data};
        if (hold_en && m_hv && m_hrd == s) return {2'b11, m_hdata};
        return {2'b00, rf};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hv <= 1'b0; m_hrd <= '0; m_hdata <= '0;
            for (int k = 0; k < 2; k++) begin m_owed[k] <= 0; m_cnt[k] <= 0; end
        end else begin
            m_hv    <= wb_regwrite && (wb_rd != 5'd0);
            m_hrd   <= wb_rd;
            m_hdata <= wb_data;
            for (int k = 0; k < 2; k++) begin
                if (m_stall(k) && m_cnt[k] < 65535) m_cnt[k] <= m_cnt[k] + 1;
                if (pipe_flush)        m_owed[k] <= 0;
                else if (m_owed[k] > 0) m_owed[k] <= m_owed[k] - 1;
                else if (m_hz())        m_owed[k] <= m_lat[k] - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_inst(input int k, input logic [31:0] oa, input logic [31:0] ob,
                            input logic [31:0] sd, input logic [1:0] fa, input logic [1:0] fb,
                            input logic st, input logic bu, input logic [15:0] cnt);
        logic [33:0] a, b;
        a = m_fwd(ex_rs, ex_rs_data, m_hold_en[k]);
        b = m_fwd(ex_rt, ex_rt_data, m_hold_en[k]);
        chk($sformatf("i%0d fwd_a", k), {30'd0, fa}, {30'd0, a[33:32]});
        chk($sformatf("i%0d fwd_b", k), {30'd0, fb}, {30'd0, b[33:32]});
        chk($sformatf("i%0d op_a", k), oa, a[31:0]);
        chk($sformatf("i%0d op_b", k), ob, ex_alusrc ? ex_imm : b[31:0]);
        chk($sformatf("i%0d store_data", k), sd, b[31:0]);
        chk($sformatf("i%0d stall", k), {31'd0, st}, {31'd0, m_stall(k)});
        chk($sformatf("i%0d bubble", k), {31'd0, bu}, {31'd0, m_stall(k)});
        chk($sformatf("i%0d stall_cnt", k), {16'd0, cnt}, 32'(m_cnt[k]));
    endtask

    always @(negedge clk) begin
        chk_inst(0, op_a_h, op_b_h, sd_h, fa_h, fb_h, st_h, bu_h, cnt_h);
        chk_inst(1, op_a_l, op_b_l, sd_l, fa_l, fb_l, st_l, bu_l, cnt_l);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_idle();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_memread = 0; ex_alusrc = 0;
        ex_rs_data = 0; ex_rt_data = 0; ex_imm = 0;
        mem_rd = 0; mem_regwrite = 0; mem_alu_out = 0;
        wb_rd = 0; wb_regwrite = 0; wb_data = 0; pipe_flush = 0;
    endtask

    task automatic drive_load_hz();
        ex_memread = 1; ex_rd = 5'd4; id_rs = 5'd4; id_use_rs = 1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        drive_idle();
        drive_load_hz();
        @(negedge clk);
        chk("reset stall", {31'd0, st_h}, 32'd0);
        chk("reset stall_cnt", {16'd0, cnt_h}, 32'd0);
        drive_idle();
        step();
        rst_n = 1;

        // MEM wins over WB for the same register
        ex_rs = 3; mem_rd = 3; mem_alu_out = 32'hAAAA0000; mem_regwrite = 1;
        wb_rd = 3; wb_data = 32'h11111111; wb_regwrite = 1;
        @(negedge clk);
        chk("mem_prio fwd_a", {30'd0, fa_h}, 32'h2);
        chk("mem_prio op_a", op_a_h, 32'hAAAA0000);
        step();

        // r0 is never forwarded
        drive_idle();
        ex_rt = 0; mem_rd = 0; mem_regwrite = 1; ex_rt_data = 32'h5;
        @(negedge clk);
        chk("r0 fwd_b", {30'd0, fb_h}, 32'h0);
        chk("r0 op_b", op_b_h, 32'h5);
        step();

        // immediate operand still forwards store data
        drive_idle();
        ex_alusrc = 1; ex_imm = 32'h10; ex_rt = 7; wb_rd = 7; wb_data = 32'hDEAD; wb_regwrite = 1;
        @(negedge clk);
        chk("imm op_b", op_b_h, 32'h10);
        chk("imm store_data", sd_h, 32'hDEAD);
        chk("imm fwd_b", {30'd0, fb_h}, 32'h1);
        step();

        // WB-hold source, one cycle after the write
        drive_idle();
        wb_rd = 9; wb_data = 32'h1234; wb_regwrite = 1;
        step();
        drive_idle();
        ex_rs = 9; ex_rs_data = 32'hCAFE;
        @(negedge clk);
        chk("hold fwd_a", {30'd0, fa_h}, 32'h3);
        chk("hold op_a", op_a_h, 32'h1234);
        chk("nohold fwd_a", {30'd0, fa_l}, 32'h0);
        chk("nohold op_a", op_a_l, 32'hCAFE);

        // load-use stall lasts exactly LOAD_LAT=3 cycles
        do_reset();
        drive_load_hz();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("lu stall c%0d", c), {31'd0, st_h}, 32'd1);
            chk($sformatf("lu bubble c%0d", c), {31'd0, bu_h}, 32'd1);
            chk($sformatf("lu cnt c%0d", c), {16'd0, cnt_h}, 32'(c));
            step();
            drive_idle();
        end
        @(negedge clk);
        chk("lu stall end", {31'd0, st_h}, 32'd0);
        chk("lu cnt end", {16'd0, cnt_h}, 32'd3);

        // flush in the second stall cycle
        do_reset();
        drive_load_hz();
        step();
        drive_idle();
        pipe_flush = 1;
        @(negedge clk);
        chk("flush stall", {31'd0, st_h}, 32'd0);
        step();
        drive_idle();
        @(negedge clk);
        chk("flush idle stall", {31'd0, st_h}, 32'd0);
        chk("flush cnt", {16'd0, cnt_h}, 32'd1);

        // reset asserted mid-WAIT
        step();
        drive_load_hz();
        step();
        drive_idle();
        @(negedge clk);
        chk("wait stall", {31'd0, st_h}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("rst stall", {31'd0, st_h}, 32'd0);
        chk("rst cnt", {16'd0, cnt_h}, 32'd0);
        @(posedge clk); #3 rst_n = 1;
        repeat (2) begin
            @(negedge clk);
            chk("post rst stall", {31'd0, st_h}, 32'd0);
            step();
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            id_rs = 5'($urandom_range(0, 7));    id_rt = 5'($urandom_range(0, 7));
            id_use_rs = 1'($urandom);            id_use_rt = 1'($urandom);
            ex_rs = 5'($urandom_range(0, 7));    ex_rt = 5'($urandom_range(0, 7));
            ex_rd = 5'($urandom_range(0, 7));    ex_memread = ($urandom_range(0, 2) == 0);
            ex_alusrc = 1'($urandom);
            ex_rs_data = $urandom; ex_rt_data = $urandom; ex_imm = $urandom;
            mem_rd = 5'($urandom_range(0, 7));   mem_regwrite = 1'($urandom);
            mem_alu_out = $urandom;
            wb_rd = 5'($urandom_range(0, 7));    wb_regwrite = 1'($urandom);
            wb_data = $urandom;
            pipe_flush = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 0;
                #2 rst_n = 1;
            end
            step();
        end

        drive_idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width.
REQ-002 SHALL have parameter AW, default 5, register-address width.
REQ-003 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles, legal range 1..4.
REQ-004 SHALL have parameter FWD_HOLD, default 1; 1 enables the WB-hold forwarding source.
REQ-005 SHALL have ports `clk` (in, 1) and `rst_n` (in, 1); one clock, asynchronous active-low reset.
REQ-006 SHALL have ID-stage inputs `id_rs` and `id_rt` (in, AW) and `id_use_rs` and `id_use_rt` (in, 1), the ID source registers and their use flags.
REQ-007 SHALL have EX-stage inputs `ex_rs`, `ex_rt` and `ex_rd` (in, AW), `ex_memread` (in, 1), `ex_alusrc` (in, 1), `ex_rs_data`, `ex_rt_data` and `ex_imm` (in, DW).
REQ-008 SHALL have MEM-stage inputs `mem_rd` (in, AW), `mem_regwrite` (in, 1) and `mem_alu_out` (in, DW).
REQ-009 SHALL have WB-stage inputs `wb_rd` (in, AW), `wb_regwrite` (in, 1) and `wb_data` (in, DW).
REQ-010 SHALL have input `pipe_flush` (in, 1), the branch-taken flush.
REQ-011 SHALL have outputs `op_a`, `op_b` and `store_data` (out, DW), the ALU operands and the store-write data.
REQ-012 SHALL have outputs `fwd_a` and `fwd_b` (out, 2), the selected sources for A and B: 00 register file, 10 MEM, 01 WB, 11 HOLD.
REQ-013 SHALL have outputs `stall` (out, 1), which freezes PC and IF/ID, and `bubble` (out, 1), which zeroes the ID/EX control signals.
REQ-014 SHALL have output `stall_cnt` (out, 16), a saturating count of stall cycles.

Function
REQ-015 SHALL, for each operand with source s (`ex_rs` for A, `ex_rt` for B), select the first matching source in this order:
- MEM, when `mem_regwrite` is high, `mem_rd` is nonzero and `mem_rd` equals s;
- WB, under the same rule using `wb_rd`;
- HOLD, when FWD_HOLD is 1, `hold_valid` is set and `hold_rd` equals s;
- otherwise the register file (`ex_rs_data` or `ex_rt_data`).
REQ-016 SHALL never forward for register 0; s equal to 0 always selects 00.
REQ-017 SHALL drive `op_a` from the forwarded A value.
REQ-018 SHALL drive `op_b` from `ex_imm` when `ex_alusrc` is 1, otherwise from the forwarded B value.
REQ-019 SHALL drive `store_data` from the forwarded B value regardless of `ex_alusrc`.
REQ-020 SHALL make `fwd_b` reflect the `ex_rt` forwarding decision even when `ex_alusrc` is 1.
REQ-021 SHALL implement the operand muxes combinationally with fully specified outputs and no inferred latches.
REQ-022 SHALL update the hold registers every cycle at the clock edge:
- `hold_rd` and `hold_data` load `wb_rd` and `wb_data`;
- `hold_valid` loads (`wb_regwrite` and `wb_rd` nonzero).
REQ-023 SHALL detect a load-use hazard, hz, when `ex_memread` is 1, `ex_rd` is nonzero, and `ex_rd` equals (`id_rs` with `id_use_rs` set) or (`id_rt` with `id_use_rt` set).
REQ-024 SHALL run an FSM with states IDLE and WAIT and a remaining-cycle counter `rem`.
REQ-025 SHALL, in IDLE, drive `stall` and `bubble` equal to hz in the same cycle (combinational).
REQ-026 SHALL, in IDLE with hz set and LOAD_LAT above 1, go to WAIT with `rem` equal to LOAD_LAT-1; with LOAD_LAT equal to 1 it SHALL stay in IDLE.
REQ-027 SHALL, in WAIT, drive `stall` and `bubble` to 1 and decrement `rem`, returning to IDLE on the edge where `rem` equals 1.
REQ-028 SHALL make `pipe_flush` take priority in any state: `stall` and `bubble` are 0 that cycle, the next state is IDLE and `rem` is 0.
REQ-029 SHALL increment `stall_cnt` on each edge where `stall` is 1, saturating at 16'hFFFF.
REQ-030 SHALL let the total stall cycles per hazard equal exactly LOAD_LAT.

Reset
REQ-031 SHALL, while `rst_n` is low, asynchronously force state to IDLE, `rem` to 0, `hold_valid` to 0, `hold_rd` to 0, `hold_data` to 0 and `stall_cnt` to 0.
REQ-032 SHALL, in reset, drive `stall` and `bubble` to 0 regardless of hz; the operand outputs follow REQ-015 to REQ-019 with HOLD disabled.
REQ-033 SHALL, when reset asserts in WAIT, abort the stall immediately with no residual stall after release.

Verification
REQ-034 SHALL cover this scenario: `ex_rs` 3; `mem_rd` 3 with `mem_alu_out` 0xAAAA0000; `wb_rd` 3 with `wb_data` 0x11111111; both regwrite flags high -> `fwd_a` 10 and `op_a` 0xAAAA0000.
REQ-035 SHALL cover this scenario: `ex_rt` 0; `mem_rd` 0 with `mem_regwrite` 1; `ex_rt_data` 0x5 -> `fwd_b` 00 and `op_b` 0x5.
REQ-036 SHALL cover this scenario: `ex_alusrc` 1, `ex_imm` 0x10, `ex_rt` 7, `wb_rd` 7, `wb_data` 0xDEAD -> `op_b` 0x10, `store_data` 0xDEAD, `fwd_b` 01.
REQ-037 SHALL cover this scenario: WB writes r9 = 0x1234 in cycle n; `ex_rs` 9 in cycle n+1 with no MEM or WB match -> `fwd_a` 11 and `op_a` 0x1234; with FWD_HOLD 0 -> `op_a` equals `ex_rs_data`.
REQ-038 SHALL cover this scenario: LOAD_LAT 3, load to r4 in EX, `id_rs` 4 with `id_use_rs` 1 -> `stall` and `bubble` high for exactly 3 cycles, `stall_cnt` 0 -> 3.
REQ-039 SHALL cover this scenario: LOAD_LAT 3, `pipe_flush` in the second stall cycle -> `stall` 0 that cycle, FSM in IDLE, `stall_cnt` 1; `rst_n` low mid-WAIT -> `stall` 0 immediately and `stall_cnt` 0.
